// File: rtl/uart_cmd_parser.sv
// Parses a snapshotted "KEY=DECIMAL" payload one byte per clock; `UART_CMD_NEG_EN enables a leading '-'.
// Result pulse in cycle L+1 (t+1 when CR/LF sits at byte t); rx_done while busy is dropped with cmd_drop.
module uart_cmd_parser #(
  parameter int MAX_BYTES = 137,
  parameter int VALUE_W   = 32
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [8*MAX_BYTES-1:0] rx_string,
  input  logic [7:0]             rx_length,
  input  logic                   rx_done,
  output logic                   parse_busy,
  output logic [7:0]             cmd_key,
  output logic [VALUE_W-1:0]     cmd_value,
  output logic                   cmd_neg,
  output logic                   cmd_vld,
  output logic                   cmd_err,
  output logic [2:0]             err_code,
  output logic                   cmd_drop
);

  typedef enum logic [2:0] {IDLE, KEY, EQ, DIGIT, DONE, ERR} state_t;

  localparam int ACC_W = VALUE_W + 4;
  localparam logic [ACC_W-1:0] LIM_POS = {4'b0, {VALUE_W{1'b1}}};
`ifdef UART_CMD_NEG_EN
  localparam logic [ACC_W-1:0] LIM_NEG = {4'b0, 1'b1, {(VALUE_W-1){1'b0}}};
`endif
  localparam logic [ACC_W-1:0] TEN     = ACC_W'(10);

  localparam logic [2:0] E_LEN   = 3'd1;
  localparam logic [2:0] E_KEY   = 3'd2;
  localparam logic [2:0] E_EQ    = 3'd3;
  localparam logic [2:0] E_DIGIT = 3'd4;
  localparam logic [2:0] E_OVF   = 3'd5;
  localparam logic [2:0] E_EMPTY = 3'd6;

  state_t                   state_q, state_d;
  logic [8*MAX_BYTES-1:0]   snap_q, snap_d;
  logic [7:0]               len_q, len_d;
  logic [7:0]               idx_q, idx_d;
  logic [VALUE_W-1:0]       acc_q, acc_d;
  logic                     dig_q, dig_d;
  logic [7:0]               key_q, key_d;
  logic [7:0]               cmd_key_q, cmd_key_d;
  logic [VALUE_W-1:0]       cmd_value_q, cmd_value_d;
  logic [2:0]               err_code_q, err_code_d;
`ifdef UART_CMD_NEG_EN
  logic                     neg_q, neg_d;
  logic                     cmd_neg_q, cmd_neg_d;
`endif

  logic [7:0]       cur_b, nxt_b;
  logic             last_b;
  logic [ACC_W-1:0] prod, lim;
  logic [2:0]       err_c;

  function automatic logic is_term(input logic [7:0] b);
    return (b == 8'h0D) || (b == 8'h0A);
  endfunction

  // The snapshot shifts down one byte per step, so the byte under test is always at the bottom.
  assign cur_b  = snap_q[7:0];
  assign nxt_b  = snap_q[15:8];
  assign last_b = (idx_q == len_q - 8'd1);
  assign prod   = {4'b0, acc_q} * TEN + {{(ACC_W-4){1'b0}}, cur_b[3:0]};
`ifdef UART_CMD_NEG_EN
  assign lim    = neg_q ? LIM_NEG : LIM_POS;
`else
  assign lim    = LIM_POS;
`endif

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    len_d       = len_q;
    idx_d       = idx_q;
    acc_d       = acc_q;
    dig_d       = dig_q;
    key_d       = key_q;
    cmd_key_d   = cmd_key_q;
    cmd_value_d = cmd_value_q;
    err_code_d  = err_code_q;
    err_c       = 3'd0;
`ifdef UART_CMD_NEG_EN
    neg_d       = neg_q;
    cmd_neg_d   = cmd_neg_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (rx_done) begin
          snap_d = rx_string;
          len_d  = rx_length;
          idx_d  = 8'd0;
          acc_d  = '0;
          dig_d  = 1'b0;
`ifdef UART_CMD_NEG_EN
          neg_d  = 1'b0;
`endif
          if (rx_length < 8'd3 || int'(rx_length) > MAX_BYTES) err_c = E_LEN;
          else state_d = KEY;
        end
      end
      KEY: begin
        if (cur_b inside {[8'h41:8'h5A]}) key_d = cur_b;
        else if (cur_b inside {[8'h61:8'h7A]}) key_d = cur_b - 8'h20;
        else err_c = E_KEY;
        state_d = EQ;
        snap_d  = snap_q >> 8;
        idx_d   = 8'd1;
      end
      EQ: begin
        if (cur_b != 8'h3D) err_c = E_EQ;
        state_d = DIGIT;
        snap_d  = snap_q >> 8;
        idx_d   = 8'd2;
      end
      DIGIT: begin
        if (cur_b inside {[8'h30:8'h39]}) begin
          if (prod > lim) begin
            err_c = E_OVF;
          end else begin
            acc_d = prod[VALUE_W-1:0];
            dig_d = 1'b1;
            // Peeking at the next byte lets a terminator finish the command without its own cycle.
            if (last_b || is_term(nxt_b)) begin
              state_d = DONE;
            end else begin
              snap_d = snap_q >> 8;
              idx_d  = idx_q + 8'd1;
            end
          end
        end else if (is_term(cur_b)) begin
          if (dig_q) state_d = DONE;
          else err_c = E_EMPTY;
        end
`ifdef UART_CMD_NEG_EN
        else if (cur_b == 8'h2D && idx_q == 8'd2) begin
          neg_d = 1'b1;
          if (last_b) begin
            err_c = E_EMPTY;
          end else begin
            snap_d = snap_q >> 8;
            idx_d  = idx_q + 8'd1;
          end
        end
`endif
        else begin
          err_c = E_DIGIT;
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (err_c != 3'd0) begin
      state_d    = ERR;
      err_code_d = err_c;
    end
    if (state_d == DONE) begin
      cmd_key_d   = key_q;
      cmd_value_d = acc_d;
`ifdef UART_CMD_NEG_EN
      cmd_neg_d   = neg_d;
`endif
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      dig_q       <= 1'b0;
      key_q       <= '0;
      cmd_key_q   <= '0;
      cmd_value_q <= '0;
      err_code_q  <= '0;
`ifdef UART_CMD_NEG_EN
      neg_q       <= 1'b0;
      cmd_neg_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      acc_q       <= acc_d;
      dig_q       <= dig_d;
      key_q       <= key_d;
      cmd_key_q   <= cmd_key_d;
      cmd_value_q <= cmd_value_d;
      err_code_q  <= err_code_d;
`ifdef UART_CMD_NEG_EN
      neg_q       <= neg_d;
      cmd_neg_q   <= cmd_neg_d;
`endif
    end
  end

  assign parse_busy = (state_q != IDLE);
  assign cmd_vld    = (state_q == DONE);
  assign cmd_err    = (state_q == ERR);
  assign cmd_drop   = rx_done && (state_q != IDLE);
  assign cmd_key    = cmd_key_q;
  assign cmd_value  = cmd_value_q;
  assign err_code   = err_code_q;
`ifdef UART_CMD_NEG_EN
  assign cmd_neg    = cmd_neg_q;
`else
  assign cmd_neg    = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomised scoreboard bench for uart_cmd_parser against a string-level reference parser.
module tb_uart_cmd_parser;

  localparam int MAX_BYTES = 137;
  localparam int VALUE_W   = 32;
`ifdef UART_CMD_NEG_EN
  localparam bit NEG_EN = 1'b1;
`else
  localparam bit NEG_EN = 1'b0;
`endif

  logic                   sys_clk = 1'b0;
  logic                   sys_rst_n;
  logic [8*MAX_BYTES-1:0] rx_string;
  logic [7:0]             rx_length;
  logic                   rx_done;
  logic                   parse_busy;
  logic [7:0]             cmd_key;
  logic [VALUE_W-1:0]     cmd_value;
  logic                   cmd_neg;
  logic                   cmd_vld;
  logic                   cmd_err;
  logic [2:0]             err_code;
  logic                   cmd_drop;

  uart_cmd_parser #(.MAX_BYTES(MAX_BYTES), .VALUE_W(VALUE_W)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_string(rx_string),
    .rx_length(rx_length), .rx_done(rx_done), .parse_busy(parse_busy),
    .cmd_key(cmd_key), .cmd_value(cmd_value), .cmd_neg(cmd_neg),
    .cmd_vld(cmd_vld), .cmd_err(cmd_err), .err_code(err_code), .cmd_drop(cmd_drop)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit               is_err;
    byte unsigned     key;
    longint unsigned  value;
    bit               neg;
    int               code;
    int               cyc;
  } resp_t;

  resp_t exp_q[$];
  int    drop_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    free_cyc = 0;

  byte unsigned    last_key = 0;
  longint unsigned last_val = 0;
  bit              last_neg = 0;
  int              last_code = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference parser: walks the string directly and reports the result cycle relative to rx_done.
  function automatic resp_t model(input byte unsigned s[$], input int len);
    resp_t r;
    longint unsigned v = 0, lim;
    int nd = 0;
    bit ng = 0;
    byte unsigned c, k;
    r.is_err = 1; r.key = last_key; r.value = last_val; r.neg = last_neg; r.code = 0; r.cyc = 0;
    if (len < 3 || len > MAX_BYTES) begin r.code = 1; r.cyc = 1; return r; end
    c = s[0];
    if (c >= 8'h41 && c <= 8'h5A) k = c;
    else if (c >= 8'h61 && c <= 8'h7A) k = c - 8'h20;
    else begin r.code = 2; r.cyc = 2; return r; end
    if (s[1] != 8'h3D) begin r.code = 3; r.cyc = 3; return r; end
    for (int i = 2; i < len; i++) begin
      c = s[i];
      if (c == 8'h0D || c == 8'h0A) begin
        if (nd == 0) begin r.code = 6; r.cyc = i + 2; return r; end
        r.is_err = 0; r.key = k; r.value = v; r.neg = ng; r.code = last_code; r.cyc = i + 1;
        return r;
      end else if (c >= 8'h30 && c <= 8'h39) begin
        v = v * 10 + longint'(c - 8'h30);
        nd++;
        lim = ng ? (64'd1 << (VALUE_W - 1)) : ((64'd1 << VALUE_W) - 64'd1);
        if (v > lim) begin r.code = 5; r.cyc = i + 2; return r; end
      end else if (NEG_EN && c == 8'h2D && i == 2) begin
        ng = 1;
      end else begin
        r.code = 4; r.cyc = i + 2; return r;
      end
    end
    if (nd == 0) begin r.code = 6; r.cyc = len + 1; return r; end
    r.is_err = 0; r.key = k; r.value = v; r.neg = ng; r.code = last_code; r.cyc = len + 1;
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic wait_free();
    while (cyc < free_cyc) begin @(posedge sys_clk); #1; end
  endtask

  task automatic send_q(input byte unsigned s[$], input int len);
    resp_t r;
    for (int k = 0; k < MAX_BYTES; k++)
      rx_string[8*k +: 8] = (k < s.size()) ? s[k] : 8'($urandom);
    rx_length = 8'(len);
    rx_done   = 1'b1;
    if (cyc >= free_cyc) begin
      r = model(s, len);
      r.cyc += cyc;
      exp_q.push_back(r);
      free_cyc = r.cyc + 1;
      if (!r.is_err) begin last_key = r.key; last_val = r.value; last_neg = r.neg; end
      else last_code = r.code;
    end else begin
      drop_q.push_back(cyc);
    end
    @(posedge sys_clk); #1;
    rx_done = 1'b0;
  endtask

  task automatic send_s(input string str, input int len = -1);
    byte unsigned s[$];
    for (int i = 0; i < str.len(); i++) s.push_back(str[i]);
    send_q(s, (len < 0) ? s.size() : len);
  endtask

  task automatic rand_cmd(output byte unsigned s[$], output int len);
    int sel, nd;
    s = {};
    sel = $urandom_range(0, 19);
    if (sel == 0) s.push_back(8'h35);
    else if (sel == 1) s.push_back(8'h40);
    else if (sel < 10) s.push_back(8'(8'h41 + $urandom_range(0, 25)));
    else s.push_back(8'(8'h61 + $urandom_range(0, 25)));
    s.push_back(($urandom_range(0, 14) == 0) ? 8'h3A : 8'h3D);
    if ($urandom_range(0, 4) == 0) s.push_back(8'h2D);
    nd = $urandom_range(0, 11);
    for (int i = 0; i < nd; i++) begin
      if ($urandom_range(0, 39) == 0) s.push_back(8'h78);
      else if ($urandom_range(0, 39) == 0) s.push_back(8'h2D);
      else s.push_back(8'(8'h30 + $urandom_range(0, 9)));
    end
    case ($urandom_range(0, 5))
      0: s.push_back(8'h0D);
      1: begin s.push_back(8'h0D); s.push_back(8'h0A); s.push_back(8'h31); end
      2: s.push_back(8'h0A);
      default: ;
    endcase
    len = s.size();
    if ($urandom_range(0, 24) == 0) len = $urandom_range(0, 2);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  parse_busy, 0);
    chk({tag, "_key"},   cmd_key,    0);
    chk({tag, "_value"}, cmd_value,  0);
    chk({tag, "_neg"},   cmd_neg,    0);
    chk({tag, "_vld"},   cmd_vld,    0);
    chk({tag, "_err"},   cmd_err,    0);
    chk({tag, "_code"},  err_code,   0);
    chk({tag, "_drop"},  cmd_drop,   0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result or a drop.
  always @(negedge sys_clk) begin
    resp_t e;
    int d;
    if (cmd_vld || cmd_err) begin
      chk("vld_err_exclusive", cmd_vld & cmd_err, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_result", cmd_vld | cmd_err, 0);
      end else begin
        e = exp_q.pop_front();
        chk("result_cycle", cyc, e.cyc);
        chk("is_err", cmd_err, e.is_err);
        chk("key", cmd_key, e.key);
        chk("value", cmd_value, e.value);
        chk("neg", cmd_neg, e.neg);
        chk("err_code", err_code, e.code);
      end
    end
    while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("missing_result", cyc, e.cyc);
    end
    if (cmd_drop) begin
      if (drop_q.size() == 0) chk("unexpected_drop", cmd_drop, 0);
      else begin d = drop_q.pop_front(); chk("drop_cycle", cyc, d); end
    end
    while (drop_q.size() != 0 && drop_q[0] < cyc) begin
      d = drop_q.pop_front();
      chk("missing_drop", cyc, d);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    byte unsigned s[$];
    int len;

    sys_rst_n = 1'b0;
    rx_string = '0;
    rx_length = '0;
    rx_done   = 1'b0;
    idle(3);
    chk_all_zero("reset");
    sys_rst_n = 1'b1;
    free_cyc  = cyc + 1;
    idle(2);
    chk_all_zero("post_reset");

    send_s("F=1000");        wait_free();
    send_s("a=5\r\n");       wait_free();
    send_s("F=12x4");        wait_free();
    send_s("5=1");           wait_free();
    send_s("F:1");           wait_free();
    send_s("F=");            wait_free();
    send_s("F=\r");          wait_free();
    send_s("F=007");         wait_free();
    send_s("V=4294967295");  wait_free();
    send_s("V=4294967296");  wait_free();
    send_s("F=-250");        wait_free();
    send_s("F=-");           wait_free();
    send_s("x=-2147483648"); wait_free();
    send_s("x=-2147483649"); wait_free();
    send_s("Q=12-3");        wait_free();
    send_s("k=99", 0);       wait_free();

    // Drops: 3 cycles in, during the DONE cycle, then an immediate accept after DONE.
    send_s("F=1000");
    idle(2);
    send_s("G=77");
    while (cyc < free_cyc - 1) idle(1);
    send_s("H=1");
    send_s("J=42");
    send_s("F:1");
    idle(1);
    send_s("K=3");
    wait_free();

    // Reset while in DIGIT: no result, outputs cleared.
    send_s("F=123456");
    idle(3);
    sys_rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    exp_q.delete();
    drop_q.delete();
    last_key = 0; last_val = 0; last_neg = 0; last_code = 0;
    idle(1);
    sys_rst_n = 1'b1;
    free_cyc  = cyc + 1;
    idle(10);
    send_s("F=9z");          wait_free();

    // Full-capacity and over-capacity payloads.
    s = {8'h5A, 8'h3D};
    for (int i = 0; i < 134; i++) s.push_back(8'h30);
    s.push_back(8'h39);
    send_q(s, s.size());     wait_free();
    s.push_back(8'h31);
    send_q(s, s.size());     wait_free();

    for (int n = 0; n < 300; n++) begin
      rand_cmd(s, len);
      send_q(s, len);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(0, 6));
      else wait_free();
    end

    wait_free();
    idle(4);
    chk("pending_results", exp_q.size(), 0);
    chk("pending_drops", drop_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
